// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, arbiter FSM states and defined-opcode check
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_ASR  = 4'b0011;
  localparam logic [3:0] OP_LSL  = 4'b0100;
  localparam logic [3:0] OP_LSR  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_INV  = 4'b1001;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_HD   = 4'b1011;
  localparam logic [3:0] OP_COMP = 4'b1100;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  function automatic logic op_valid(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_COMP;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[IW'((int'(ptr) + k) % N)]) begin
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU with registered response; ALU_ARB_CARRY_CHAIN_EN adds per-requester saved carry
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DW      = 16,
  parameter int IDW     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [DW*NUM_REQ-1:0] req_a,
  input  logic [DW*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_cin,
  input  logic [NUM_REQ-1:0]    req_chain,
  output logic [3:0]            alu_op,
  output logic [DW-1:0]         alu_in1,
  output logic [DW-1:0]         alu_in2,
  output logic                  alu_cin,
  input  logic [DW-1:0]         alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_eq,
  input  logic                  alu_neg,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_eq,
  output logic                  rsp_neg,
  output logic                  rsp_err,
  output logic                  busy
);
  logic [1:0]         state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     idx;
  logic [NUM_REQ-1:0] grant;
  logic               any;
  logic               cin_sel;
  logic               ok;
  rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_rr (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (idx),
    .any  (any)
  );
  assign busy      = state != IDLE;
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign ok        = op_valid(alu_op);
`ifdef ALU_ARB_CARRY_CHAIN_EN
  logic [NUM_REQ-1:0] saved_carry;
  assign cin_sel = req_chain[idx] ? saved_carry[idx] : req_cin[idx];
  always_ff @(posedge clk) begin
    if (!rst_n)
      saved_carry <= '0;
    else if (state == EXEC && alu_op == OP_ADD)
      saved_carry[rsp_id] <= alu_carry;
  end
`else
  logic unused_chain;
  assign unused_chain = ^req_chain;
  assign cin_sel      = req_cin[idx];
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      alu_op     <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_eq     <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        state   <= EXEC;
        alu_op  <= req_op[int'(idx)*4 +: 4];
        alu_in1 <= req_a[int'(idx)*DW +: DW];
        alu_in2 <= req_b[int'(idx)*DW +: DW];
        alu_cin <= cin_sel;
        rsp_id  <= idx;
      end
      // undefined opcodes still occupy the ALU but report zeros
      if (state == EXEC) begin
        state      <= RESP;
        rsp_valid  <= 1'b1;
        rsp_err    <= !ok;
        rsp_result <= ok ? alu_result : '0;
        rsp_carry  <= ok && alu_carry;
        rsp_eq     <= ok && alu_eq;
        rsp_neg    <= ok && alu_neg;
      end
      if (state == RESP && rsp_ready) begin
        state     <= IDLE;
        rsp_valid <= 1'b0;
        rr_ptr    <= rsp_id == IDW'(NUM_REQ - 1) ? '0 : rsp_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural ALU and grant/response model
module tb_alu_arbiter;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int IDW = 1;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_cin, req_chain;
  logic [4*N-1:0]  req_op;
  logic [DW*N-1:0] req_a, req_b;
  logic [3:0]      alu_op;
  logic [DW-1:0]   alu_in1, alu_in2, alu_result, rsp_result;
  logic            alu_cin, alu_carry, alu_eq, alu_neg;
  logic            rsp_valid, rsp_ready, rsp_carry, rsp_eq, rsp_neg, rsp_err, busy;
  logic [IDW-1:0]  rsp_id;
  int              checks = 0;
  int              errors = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.NUM_REQ(N), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_chain(req_chain),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_eq(alu_eq), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_eq(rsp_eq), .rsp_neg(rsp_neg), .rsp_err(rsp_err), .busy(busy)
  );
  function automatic logic [18:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic c, e, n;
    s = '0;
    r = '0;
    c = 1'b0;
    e = 1'b0;
    n = 1'b0;
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b} + {16'd0, cin}; r = s[15:0]; c = s[16]; end
      4'd2: begin r = (a >= b) ? a - b : b - a; n = a < b; end
      4'd3: r = $signed(a) >>> b[3:0];
      4'd4: r = a << b[3:0];
      4'd5: r = a >> b[3:0];
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = {15'd0, $signed(a) < $signed(b)};
      4'd9: r = ~a;
      4'd10: r = b;
      4'd11: begin r = 16'($countones(a ^ b)); e = a == b; end
      4'd12: e = a == b;
      default: begin r = a ^ b ^ 16'hA5A5; c = 1'b1; e = 1'b1; n = 1'b1; end
    endcase
    return {c, e, n, r};
  endfunction
  function automatic logic [19:0] expect_rsp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    return (op >= 4'd1 && op <= 4'd12) ? {1'b0, alu_model(op, a, b, cin)} : {1'b1, 19'd0};
  endfunction
  always_comb {alu_carry, alu_eq, alu_neg, alu_result} = alu_model(alu_op, alu_in1, alu_in2, alu_cin);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_req;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_cin = '0; req_chain = '0;
  endtask
  task automatic do_reset;
    clear_req();
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin, input logic chain);
    req_valid[i] = 1'b1; req_op[i*4 +: 4] = op; req_a[i*16 +: 16] = a; req_b[i*16 +: 16] = b; req_cin[i] = cin; req_chain[i] = chain;
  endtask
  task automatic test_reset;
    clear_req();
    req_valid = '1;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h exp 0", rsp_valid); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %0h exp 0", req_ready); end
    checks++; if ({alu_op, alu_in1, alu_in2, alu_cin} !== '0) begin errors++; $display("FAIL reset_alu got %0h/%0h/%0h exp 0", alu_op, alu_in1, alu_in2); end
    checks++; if ({rsp_id, rsp_result, rsp_carry, rsp_eq, rsp_neg, rsp_err} !== '0) begin errors++; $display("FAIL reset_rsp got %0h exp 0", rsp_result); end
    rst_n = 1'b1;
    clear_req();
  endtask
  task automatic test_single_add;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 4'd1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_ready got %0b exp 01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_exec got valid=%0b busy=%0b exp 0/1", rsp_valid, busy); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency got %0b exp 1", rsp_valid); end
    checks++; if ({rsp_result, rsp_carry, rsp_id, rsp_err} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL add_rsp got res=%0h c=%0b id=%0d err=%0b exp 0/1/0/0", rsp_result, rsp_carry, rsp_id, rsp_err); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_done got valid=%0b busy=%0b exp 0/0", rsp_valid, busy); end
  endtask
  task automatic test_sub_mov;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 4'd2, 16'd3, 16'd5, 1'b0, 1'b0);
    set_req(1, 4'd10, 16'd0, 16'h1234, 1'b0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      #1;
      checks++; if (req_ready !== 2'(1 << (g % 2))) begin errors++; $display("FAIL alt_grant%0d got %0b exp %0b", g, req_ready, 2'(1 << (g % 2))); end
      tick();
      tick();
      checks++; if (rsp_id !== 1'(g % 2)) begin errors++; $display("FAIL alt_id%0d got %0d exp %0d", g, rsp_id, g % 2); end
      checks++; if ({rsp_result, rsp_neg, rsp_err} !== ((g % 2) ? {16'h1234, 1'b0, 1'b0} : {16'h0002, 1'b1, 1'b0})) begin errors++; $display("FAIL alt_rsp%0d got res=%0h neg=%0b err=%0b", g, rsp_result, rsp_neg, rsp_err); end
      tick();
    end
    clear_req();
  endtask
  task automatic test_backpressure;
    do_reset();
    set_req(0, 4'd1, 16'd2, 16'd3, 1'b0, 1'b0);
    set_req(1, 4'd7, 16'h00F0, 16'h0F00, 1'b0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err} !== {1'b1, 1'b0, 16'd5, 1'b0, 1'b0}) begin errors++; $display("FAIL bp_hold%0d got v=%0b id=%0d res=%0h", i, rsp_valid, rsp_id, rsp_result); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %0b exp 00", i, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %0b exp 0", rsp_valid); end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_resume got %0b exp 10", req_ready); end
    req_valid = '0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_withdraw got busy=%0b exp 0", busy); end
  endtask
  task automatic test_undef;
    logic [3:0] ops [4] = '{4'd0, 4'd13, 4'd14, 4'd15};
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(0, ops[i], 16'h00FF, 16'h00FF, 1'b1, 1'b0);
      tick();
      req_valid = '0;
      tick();
      checks++; if ({rsp_valid, rsp_err, rsp_result, rsp_carry, rsp_eq, rsp_neg} !== {2'b11, 19'd0}) begin errors++; $display("FAIL undef_op%0d got v=%0b err=%0b res=%0h c=%0b e=%0b n=%0b", ops[i], rsp_valid, rsp_err, rsp_result, rsp_carry, rsp_eq, rsp_neg); end
      tick();
    end
  endtask
  task automatic test_reset_exec;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 4'd1, 16'd1, 16'd1, 1'b0, 1'b0);
    tick();
    req_valid = '0;
    tick();
    tick();
    set_req(0, 4'd7, 16'd1, 16'd2, 1'b0, 1'b0);
    set_req(1, 4'd6, 16'd3, 16'd6, 1'b0, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rexec_pre got %0b exp 10", req_ready); end
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_state got busy=%0b v=%0b exp 0/0", busy, rsp_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_ghost%0d got %0b exp 0", i, rsp_valid); end
      tick();
    end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rexec_ptr got %0b exp 01", req_ready); end
    req_valid = '0;
    tick();
  endtask
  task automatic test_carry_chain;
    logic [15:0] exp_res;
`ifdef ALU_ARB_CARRY_CHAIN_EN
    exp_res = 16'h0001;
`else
    exp_res = 16'h0000;
`endif
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 4'd1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();
    req_valid = '0;
    tick();
    checks++; if ({rsp_result, rsp_carry} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL chain_lo got res=%0h c=%0b exp 0/1", rsp_result, rsp_carry); end
    tick();
    set_req(0, 4'd1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick();
    req_valid = '0;
    checks++; if (alu_cin !== exp_res[0]) begin errors++; $display("FAIL chain_cin got %0b exp %0b", alu_cin, exp_res[0]); end
    tick();
    checks++; if (rsp_result !== exp_res) begin errors++; $display("FAIL chain_hi got %0h exp %0h", rsp_result, exp_res); end
    tick();
  endtask
  task automatic test_random;
    int          mptr, w, stall;
    logic [N-1:0] saved;
    logic [3:0]  eop;
    logic [15:0] ea, eb;
    logic        ecin;
    logic [19:0] exp;
    do_reset();
    mptr = 0;
    saved = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) req_valid[i] = 1'($urandom_range(0, 1));
        if (req_valid[i]) set_req(i, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      if (req_valid == '0) set_req($urandom_range(0, N - 1), 4'd1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      w = mptr;
      while (!req_valid[w]) w = (w + 1) % N;
      eop = req_op[w*4 +: 4];
      ea = req_a[w*16 +: 16];
      eb = req_b[w*16 +: 16];
`ifdef ALU_ARB_CARRY_CHAIN_EN
      ecin = req_chain[w] ? saved[w] : req_cin[w];
`else
      ecin = req_cin[w];
`endif
      exp = expect_rsp(eop, ea, eb, ecin);
      #1;
      checks++; if (req_ready !== N'(1 << w)) begin errors++; $display("FAIL rnd_grant%0d got %0b exp %0b", t, req_ready, N'(1 << w)); end
      tick();
      req_valid[w] = 1'b0;
      checks++; if ({alu_op, alu_in1, alu_in2, alu_cin} !== {eop, ea, eb, ecin}) begin errors++; $display("FAIL rnd_alu%0d got %0h/%0h/%0h/%0b exp %0h/%0h/%0h/%0b", t, alu_op, alu_in1, alu_in2, alu_cin, eop, ea, eb, ecin); end
      for (int i = 0; i < N; i++)
        if (req_valid[i]) begin req_a[i*16 +: 16] = 16'($urandom); req_op[i*4 +: 4] = 4'($urandom_range(0, 15)); end
      tick();
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_carry, rsp_eq, rsp_neg, rsp_result} !== {1'b1, 1'(w), exp}) begin errors++; $display("FAIL rnd_rsp%0d got v=%0b id=%0d err=%0b flags=%0b%0b%0b res=%0h exp id=%0d %0h", t, rsp_valid, rsp_id, rsp_err, rsp_carry, rsp_eq, rsp_neg, rsp_result, w, exp); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rnd_busy_ready%0d got %0b exp 0", t, req_ready); end
        if (s == stall) rsp_ready = 1'b1;
        tick();
      end
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_drop%0d got %0b exp 0", t, rsp_valid); end
      if (eop == 4'd1) saved[w] = exp[18];
      mptr = (w + 1) % N;
    end
    clear_req();
  endtask
  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    clear_req();
    test_reset();
    test_single_add();
    test_sub_mov();
    test_backpressure();
    test_undef();
    test_reset_exec();
    test_carry_chain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 16-bit ALU between NUM_REQ requesters, e.g. PC-increment and execute unit.
- Round-robin grant; latches the winner's op and operands, drives the ALU for one cycle, then registers result and flags.
- Holds the response under a valid/ready handshake back to the winning requester.
- Sits between the issue logic and the ALU instance in the datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DW, 16, operand/result width (must match the ALU).
- IDW, 1, requester-id width, equal to clog2(NUM_REQ), minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request
- req_ready  output  NUM_REQ  one-hot accept strobe
- req_op  input  4*NUM_REQ  ALU opcode per requester
- req_a  input  DW*NUM_REQ  in1 per requester
- req_b  input  DW*NUM_REQ  in2 per requester
- req_cin  input  NUM_REQ  carry_in per requester
- req_chain  input  NUM_REQ  use saved carry (optional feature only)
- alu_op  output  4  to ALU operation
- alu_in1  output  DW  to ALU in1
- alu_in2  output  DW  to ALU in2
- alu_cin  output  1  to ALU carry_in
- alu_result  input  DW  from ALU
- alu_carry, alu_eq, alu_neg  input  1 each  ALU flags
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  IDW  requester index
- rsp_result  output  DW  registered result
- rsp_carry, rsp_eq, rsp_neg  output  1 each  registered flags
- rsp_err  output  1  undefined opcode
- busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: all outputs 0; state IDLE; rr_ptr 0. A reset mid-operation drops the in-flight op, and no response is issued.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Winner = first requester with req_valid set, searching from rr_ptr upward with wrap.
  - req_ready[winner] is asserted combinationally in the same cycle. Accept happens on valid&ready.
  - On accept, latch op, a, b, cin and id into the alu_* registers and go to EXEC.
  - No valid request: stay in IDLE, req_ready = 0.
- EXEC:
  - alu_* registers are stable and the ALU settles.
  - At the end of the cycle, capture alu_result and the flags into the rsp_* registers, then go to RESP.
- RESP:
  - rsp_valid = 1; all rsp_* fields are held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid drops next cycle, rr_ptr = (id+1) mod NUM_REQ, go to IDLE.
- Latency and throughput:
  - Accept at cycle T gives rsp_valid at T+2.
  - With rsp_ready tied high, the minimum issue interval is 3 cycles.
  - req_ready is 0 in EXEC and RESP.
- Opcodes:
  - 0000 and 1101..1111 are undefined. They are still issued, but rsp_err = 1, rsp_result = 0, and all rsp flags = 0, regardless of ALU outputs.
  - Defined opcodes give rsp_err = 0.
- Flags are captured verbatim from the ALU:
  - carry is meaningful only for ADD.
  - neg is meaningful only for SUB.
  - eq is meaningful only for HD/COMP.
  - The arbiter does not mask them.
- alu_cin = latched req_cin. The ALU uses it only for ADD.
- A requester must hold valid and its payload until accepted. Dropping valid before accept means no grant. Payload changes before accept are allowed; the value latched is the one present in the accept cycle.
- Simultaneous requests: exactly one grant; the others wait. Starvation-free: every waiting requester is granted within NUM_REQ grants.
- alu_* outputs keep the last issued values while IDLE; they are not zeroed.

Optional Feature:
- Macro: ALU_ARB_CARRY_CHAIN_EN.
- Defined:
  - One saved_carry bit per requester, reset to 0.
  - On capture of an ADD (0001) for requester i, saved_carry[i] = alu_carry.
  - On accept with req_chain[i] = 1, alu_cin = saved_carry[i] instead of req_cin.
  - Enables multi-word addition.
- Undefined:
  - req_chain is ignored; alu_cin = req_cin always; no saved_carry storage.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode constants ADD=0001, SUB=0010, ASR=0011, LSL=0100, LSR=0101, AND=0110, OR=0111, SLT=1000, INV=1001, MOV=1010, HD=1011, COMP=1100.
  - An op_valid function (defined opcodes).
  - State enum IDLE/EXEC/RESP.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any.
  - Instantiated once.

Test Plan:
- Single ADD request:
  - Stimulus: req0 ADD a=0xFFFF, b=0x0001, cin=0, rsp_ready=1.
  - Response: req_ready[0] in the accept cycle; rsp_valid at T+2 with result=0x0000, carry=1, id=0, err=0.
- Simultaneous SUB and MOV:
  - Stimulus: both requesters valid every cycle; req0 SUB 3-5, req1 MOV b=0x1234.
  - Response: grants alternate 0,1,0,1. req0 gets result=0x0002, neg=1; req1 gets 0x1234.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid.
  - Response: rsp_* stable; req_ready stays 0 despite pending requests; grant resumes in the cycle after the rsp handshake.
- Undefined opcode:
  - Stimulus: opcode 1110 with a=0x00FF, b=0x00FF.
  - Response: rsp_err=1, rsp_result=0, carry/eq/neg=0.
- Reset in EXEC:
  - Stimulus: rst_n=0 during EXEC.
  - Response: next cycle busy=0, rsp_valid=0, rr_ptr=0; no response ever appears for the dropped op.
- Carry chain (ALU_ARB_CARRY_CHAIN_EN):
  - Stimulus: req0 ADD 0xFFFF+0x0001, then ADD 0x0000+0x0000 with chain=1.
  - Response: second result=0x0001. With the macro undefined, the same stimulus gives 0x0000.
